// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NUM_REQ requesters to a single 8N1 transmitter,
// with packet locking (owner keeps the line until req_last) and a launch-acknowledge timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_enable,
    input  logic                   tx_busy,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     owner;
    logic                 lock;
    logic                 last_flag;
    logic [7:0]           ack_cnt;

    logic [IDX_W-1:0]     win_idx;
    logic                 win_ok;
    logic [NUM_REQ-1:0]   win_onehot;
    logic [7:0]           win_data;
    int                   cand;
    logic [IDX_W-1:0]     cand_idx;

    logic                 accept;
    logic                 ack_timeout;
    logic                 done_exit;

    // A held lock pins eligibility to the owner; otherwise search round-robin after rr_ptr.
    always_comb begin
        win_idx  = '0;
        win_ok   = 1'b0;
        cand     = 0;
        cand_idx = '0;
        if (lock) begin
            win_idx = owner;
            win_ok  = req_valid[owner];
        end else begin
            for (int off = 1; off <= NUM_REQ; off++) begin
                cand = int'(rr_ptr) + off;
                if (cand >= NUM_REQ) cand = cand - NUM_REQ;
                cand_idx = IDX_W'(cand);
                if (!win_ok && req_valid[cand_idx]) begin
                    win_idx = cand_idx;
                    win_ok  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
        win_data            = req_data[{win_idx, 3'b000} +: 8];
    end

    assign req_ready = (state == IDLE && !tx_busy && win_ok && !rst) ? win_onehot : '0;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        ack_timeout = 1'b0;
        done_exit   = 1'b0;
        case (state)
            IDLE: begin
                if (|req_ready) begin
                    accept    = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: state_nxt = WAIT_ACK;
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (ack_cnt == 8'(ACK_TIMEOUT - 2)) begin
                    // this cycle's increment would reach ACK_TIMEOUT-1: give up on the byte
                    ack_timeout = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    done_exit = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_enable   <= 1'b0;
            tx_data     <= 8'h00;
            grant       <= '0;
            lock        <= 1'b0;
            owner       <= '0;
            last_flag   <= 1'b0;
            ack_cnt     <= '0;
            timeout_err <= 1'b0;
            rr_ptr      <= IDX_W'(NUM_REQ - 1);
        end else begin
            tx_enable <= accept;
            if (accept) begin
                tx_data   <= win_data;
                grant     <= win_onehot;
                last_flag <= req_last[win_idx];
                owner     <= win_idx;
            end
            if (state == LAUNCH)
                ack_cnt <= '0;
            else if (state == WAIT_ACK && !tx_busy && !ack_timeout)
                ack_cnt <= ack_cnt + 8'd1;
            if (ack_timeout) begin
                timeout_err <= 1'b1;
                lock        <= 1'b0;
                grant       <= '0;
            end
            // End of a byte: release on the last byte of a packet, otherwise keep the owner locked
            if (done_exit) begin
                if (last_flag) begin
                    lock   <= 1'b0;
                    grant  <= '0;
                    rr_ptr <= owner;
                end else begin
                    lock <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of byte requesters; the legal range is 2..8.
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 16, giving the maximum clk cycles to wait for tx_busy to rise after a launch; the legal range is 2..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its posedge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ bits: requester i holds a byte.
REQ-006 The block SHALL have port req_data, input, 8*NUM_REQ bits: byte of requester i in bits [8i+7:8i].
REQ-007 The block SHALL have port req_last, input, NUM_REQ bits: the byte of requester i ends its packet.
REQ-008 The block SHALL have port req_ready, output, NUM_REQ bits: combinational accept strobe; the byte transfers on a clk edge where req_valid[i] and req_ready[i] are both high.
REQ-009 The block SHALL have port tx_data, output, 8 bits: registered byte presented to the 8N1 transmitter.
REQ-010 The block SHALL have port tx_enable, output, 1 bit: registered one-cycle launch pulse to the transmitter.
REQ-011 The block SHALL have port tx_busy, input, 1 bit: transmitter busy flag.
REQ-012 The block SHALL have port grant, output, NUM_REQ bits: registered one-hot current owner, or all-zero when there is no owner.
REQ-013 The block SHALL have port timeout_err, output, 1 bit: sticky flag, set when an ACK_TIMEOUT occurs.

Function
REQ-014 The FSM SHALL have states IDLE, LAUNCH, WAIT_ACK and WAIT_DONE, encoded in a registered state variable.
REQ-015 In IDLE with tx_busy=0 and no packet lock, the winner SHALL be the first i with req_valid[i]=1, searching round-robin from rr_ptr+1 mod NUM_REQ.
REQ-016 In IDLE with a packet lock held by owner k, only requester k SHALL be eligible, and the other requesters SHALL wait regardless of their req_valid.
REQ-017 req_ready SHALL be one-hot at the winner only while in IDLE with tx_busy=0 and the winner valid; otherwise req_ready SHALL be all-zero.
REQ-018 On an accept edge, the block SHALL do all of the following:
- tx_data <= winner byte
- grant <= onehot(winner)
- latch last_flag <= req_last[winner]
- state <= LAUNCH
REQ-019 In LAUNCH, tx_enable SHALL be 1 for exactly that cycle, and the next state SHALL be WAIT_ACK with the timeout counter cleared; tx_enable SHALL be 0 in every other state.
- Accept at edge N gives tx_enable high in cycle N+1.
REQ-020 In WAIT_ACK, when tx_busy=1 the next state SHALL be WAIT_DONE; otherwise the counter SHALL increment.
REQ-021 If the WAIT_ACK counter reaches ACK_TIMEOUT-1 while tx_busy=0, the block SHALL do all of the following:
- set timeout_err=1
- clear the lock
- clear grant to zero
- return to IDLE, dropping the byte
REQ-022 In WAIT_DONE, when tx_busy=0 the next state SHALL be IDLE.
REQ-023 On leaving WAIT_DONE with last_flag=1, the block SHALL clear the lock, set grant to zero, and set rr_ptr to the owner index.
REQ-024 On leaving WAIT_DONE with last_flag=0, the lock SHALL be held for the owner and grant SHALL be kept.
REQ-025 tx_data SHALL remain stable from the accept edge until the next accept.
REQ-026 Boundary: if tx_busy=1 in IDLE (transmitter still busy), there SHALL be no accept and req_ready SHALL be 0.
REQ-027 Boundary: with all requesters valid and no lock, the service order SHALL rotate strictly, and no requester SHALL be served twice before the others are served once.
REQ-028 Boundary: if the locked owner drops req_valid, the block SHALL stay in IDLE, keep the lock, and not serve the other requesters.
REQ-029 Boundary: a byte with req_last=1 from an unlocked winner SHALL form a single-byte packet and SHALL NOT create a lock.
REQ-030 Boundary: req_valid or req_data changes outside an accept edge SHALL have no effect.

Reset
REQ-031 When rst=1 at a clk edge, the following SHALL take effect at the next cycle, including mid-packet or mid-WAIT:
- state=IDLE
- tx_enable=0
- tx_data=8'h00
- grant=0
- lock cleared
- last_flag=0
- counter=0
- timeout_err=0
- rr_ptr=NUM_REQ-1, so that requester 0 has first priority
REQ-032 req_ready SHALL be 0 during any cycle in which rst=1.

Verification
REQ-033 Single byte: req_valid=4'b0001, data0=8'h41, last=1, transmitter model busy 10 cycles after enable -> accept at edge N; tx_enable pulse in cycle N+1; tx_data=8'h41; grant=0001 until busy falls, then 0000.
REQ-034 Round-robin: all 4 requesters valid with last=1, bytes 8'h10..8'h13 -> launch order 0,1,2,3,0; exactly one tx_enable per busy window.
REQ-035 Packet lock: req0 sends 3 bytes (last only on the third) while req1 is continuously valid -> req1 is first accepted only after the third req0 byte completes; grant stays 0001 throughout.
REQ-036 Timeout: the transmitter model never raises busy; ACK_TIMEOUT=16 -> timeout_err=1 exactly 16 cycles after tx_enable, FSM in IDLE, grant=0, and the next request is still served.
REQ-037 Reset mid-operation: assert rst during WAIT_DONE of a locked packet -> next cycle tx_enable=0, grant=0, timeout_err=0, and the next arbitration picks requester 0 first.
